// File: rtl/queen_board_checker_if.sv
// Stream and verdict bundle between the N-queens solver (master) and the
// board checker (slave).
interface queen_board_checker_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  localparam int IW = $clog2(N);

  logic             done_in;
  logic [N-1:0]     bus_in;
  logic             busy;
  logic             result_valid;
  logic             board_ok;
  logic             err_format;
  logic             err_short;
  logic [IW-1:0]    conflict_a;
  logic [IW-1:0]    conflict_b;
  logic [CNT_W-1:0] solution_count;

  modport master (
    output done_in, bus_in,
    input  busy, result_valid, board_ok, err_format, err_short,
           conflict_a, conflict_b, solution_count
  );

  modport slave (
    input  done_in, bus_in,
    output busy, result_valid, board_ok, err_format, err_short,
           conflict_a, conflict_b, solution_count
  );
endinterface

// File: rtl/queen_board_checker.sv
// Captures an N-row one-hot board streamed while done_in is high, checks every
// row pair for column/diagonal attacks and reports a one-cycle verdict.
module queen_board_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  user_reset,
  queen_board_checker_if.slave  io
);
  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [N-1:0]  ONE  = N'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, REPORT} state_t;

  state_t        state;
  logic [N-1:0]  rows [N];
  logic [IW-1:0] row_idx;
  logic          done_q;
  logic          fmt_bad;
  logic          short_bad;
  logic          hit;
  logic [IW-1:0] hit_a;
  logic [IW-1:0] hit_b;
  logic [IW-1:0] pi;
  logic [IW-1:0] pj;

  function automatic logic one_hot(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - ONE)) == '0);
  endfunction

  function automatic logic [IW-1:0] col_of(input logic [N-1:0] x);
    logic [IW-1:0] c;
    c = '0;
    for (int b = N - 1; b >= 0; b--)
      if (x[b]) c = IW'(b);
    return c;
  endfunction

  logic [IW-1:0] col_i, col_j, col_diff;
  logic          attack, board_good;

  assign col_i      = col_of(rows[pi]);
  assign col_j      = col_of(rows[pj]);
  assign col_diff   = (col_i > col_j) ? (col_i - col_j) : (col_j - col_i);
  assign attack     = (col_i == col_j) || (col_diff == (pj - pi));
  assign board_good = !fmt_bad && !short_bad && !hit;

  // NOTE: every register here, including the row buffer, sits on the async
  // reset so a reset mid-board discards it completely; all updates are
  // non-blocking so each branch sees pre-edge values.
  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      state     <= IDLE;
      row_idx   <= '0;
      done_q    <= 1'b0;
      fmt_bad   <= 1'b0;
      short_bad <= 1'b0;
      hit       <= 1'b0;
      hit_a     <= '0;
      hit_b     <= '0;
      pi        <= '0;
      pj        <= '0;
      for (int r = 0; r < N; r++) rows[r] <= '0;
      io.busy           <= 1'b0;
      io.result_valid   <= 1'b0;
      io.board_ok       <= 1'b0;
      io.err_format     <= 1'b0;
      io.err_short      <= 1'b0;
      io.conflict_a     <= '0;
      io.conflict_b     <= '0;
      io.solution_count <= '0;
    end else begin
      done_q          <= io.done_in;
      io.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (io.done_in && !done_q) begin
            rows[0]   <= io.bus_in;
            row_idx   <= IW'(1);
            fmt_bad   <= !one_hot(io.bus_in);
            short_bad <= 1'b0;
            hit       <= 1'b0;
            hit_a     <= '0;
            hit_b     <= '0;
            io.busy   <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!io.done_in) begin
            // A short board is reported without a format verdict.
            short_bad <= 1'b1;
            fmt_bad   <= 1'b0;
            state     <= REPORT;
          end else begin
            rows[row_idx] <= io.bus_in;
            row_idx       <= row_idx + IW'(1);
            fmt_bad       <= fmt_bad || !one_hot(io.bus_in);
            if (row_idx == LAST) begin
              if (fmt_bad || !one_hot(io.bus_in)) begin
                state <= REPORT;
              end else begin
                pi    <= '0;
                pj    <= IW'(1);
                state <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (attack && !hit) begin
            hit   <= 1'b1;
            hit_a <= pi;
            hit_b <= pj;
          end
          if (pj == LAST) begin
            if (pi == IW'(N - 2)) begin
              state <= REPORT;
            end else begin
              pi <= pi + IW'(1);
              pj <= pi + IW'(2);
            end
          end else begin
            pj <= pj + IW'(1);
          end
        end
        REPORT: begin
          io.result_valid <= 1'b1;
          io.board_ok     <= board_good;
          io.err_format   <= fmt_bad;
          io.err_short    <= short_bad;
          io.conflict_a   <= hit_a;
          io.conflict_b   <= hit_b;
          if (board_good && (io.solution_count != '1))
            io.solution_count <= io.solution_count + CNT_W'(1);
          io.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
